count_time_param: RTL and testbench

//  Parametrised hour/minute/second timekeeping core for the digital clock; next generation of the fixed 24h/60/60 counter.
//  One synchronous clock domain; the 1 Hz and 5 Hz enables come from the prescaler as single-cycle strobes.

---
 rtl/count_time_param.sv | 107 ++++++++++
 tb/tb_count_time_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/count_time_param.sv
// Parametrised hour/minute/second timekeeping core with run/set modes and a day-rollover strobe.
// Optional 12-hour outputs (hour12, pm) are built when TIME_12H_EN is defined.
module count_time_param #(
  parameter int W        = 6,
  parameter int HOUR_MOD = 24,
  parameter int MIN_MOD  = 60,
  parameter int SEC_MOD  = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         ena_5hz,
  input  logic         ena_up,
  input  logic         ena_dw,
  input  logic [1:0]   select_mode,
  output logic [W-1:0] hour,
  output logic [W-1:0] min,
  output logic [W-1:0] sec,
`ifdef TIME_12H_EN
  output logic [W-1:0] hour12,
  output logic         pm,
`endif
  output logic         day_tick
);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HOUR = 2'b01;
  localparam logic [1:0] MODE_MIN  = 2'b10;
  localparam logic [1:0] MODE_SEC  = 2'b11;

  logic         up_q, dw_q;
  logic         adj_step;
  logic [W-1:0] hour_n, min_n, sec_n;
  logic         tick_n;

  function automatic logic [W-1:0] step_wrap(input logic [W-1:0] v, input logic up,
                                             input int modulus);
    if (up) return (v == W'(modulus - 1)) ? '0 : v + W'(1);
    else    return (v == '0) ? W'(modulus - 1) : v - W'(1);
  endfunction

  // One step per fresh press or per 5 Hz strobe while held; conflicting requests cancel.
  assign adj_step = (ena_up ^ ena_dw) &
                    (ena_5hz | (ena_up & ~up_q) | (ena_dw & ~dw_q));

  always_comb begin
    hour_n = hour;
    min_n  = min;
    sec_n  = sec;
    tick_n = 1'b0;
    case (select_mode)
      MODE_RUN: begin
        if (ena) begin
          sec_n = step_wrap(sec, 1'b1, SEC_MOD);
          if (sec == W'(SEC_MOD - 1)) begin
            min_n = step_wrap(min, 1'b1, MIN_MOD);
            if (min == W'(MIN_MOD - 1)) begin
              hour_n = step_wrap(hour, 1'b1, HOUR_MOD);
              tick_n = (hour == W'(HOUR_MOD - 1));
            end
          end
        end
      end
      MODE_HOUR: if (adj_step) hour_n = step_wrap(hour, ena_up, HOUR_MOD);
      MODE_MIN:  if (adj_step) min_n  = step_wrap(min,  ena_up, MIN_MOD);
      MODE_SEC:  if (adj_step) sec_n  = step_wrap(sec,  ena_up, SEC_MOD);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour     <= '0;
      min      <= '0;
      sec      <= '0;
      day_tick <= 1'b0;
      up_q     <= 1'b0;
      dw_q     <= 1'b0;
    end else begin
      hour     <= hour_n;
      min      <= min_n;
      sec      <= sec_n;
      day_tick <= tick_n;
      up_q     <= ena_up;
      dw_q     <= ena_dw;
    end
  end

`ifdef TIME_12H_EN
  localparam logic [W-1:0] TWELVE = W'(12);
  logic [W-1:0] h_mod;

  assign h_mod = hour_n % TWELVE;

  // Derived from next-state hour so the 12h view stays aligned with hour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour12 <= TWELVE;
      pm     <= 1'b0;
    end else begin
      hour12 <= (h_mod == '0) ? TWELVE : h_mod;
      pm     <= (hour_n >= TWELVE);
    end
  end
`endif

endmodule

// File: tb/tb_count_time_param.sv
// Directed bench for count_time_param: reset, run carries, day rollover, set-mode wrap and auto-repeat.
// The 12-hour checks are compiled when TIME_12H_EN is defined.
module tb_count_time_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       ena_5hz = 1'b0;
  logic       ena_up = 1'b0;
  logic       ena_dw = 1'b0;
  logic [1:0] select_mode = 2'b00;
  logic [5:0] hour, min, sec;
  logic       day_tick;
`ifdef TIME_12H_EN
  logic [5:0] hour12;
  logic       pm;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int ticks;

  count_time_param #(.W(6), .HOUR_MOD(24), .MIN_MOD(60), .SEC_MOD(60)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ena_5hz(ena_5hz),
    .ena_up(ena_up), .ena_dw(ena_dw), .select_mode(select_mode),
    .hour(hour), .min(min), .sec(sec),
`ifdef TIME_12H_EN
    .hour12(hour12), .pm(pm),
`endif
    .day_tick(day_tick)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hms(input string tag, input int eh, input int em, input int es);
    chk({tag, ".hour"}, int'(hour), eh);
    chk({tag, ".min"},  int'(min),  em);
    chk({tag, ".sec"},  int'(sec),  es);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      ena_up = 1'b1; cyc();
      ena_up = 1'b0; cyc();
    end
  endtask

  task automatic press_dw(input int n);
    for (int i = 0; i < n; i++) begin
      ena_dw = 1'b1; cyc();
      ena_dw = 1'b0; cyc();
    end
  endtask

  task automatic strobe_1hz();
    ena = 1'b1; cyc();
    ena = 1'b0;
  endtask

  task automatic strobe_5hz();
    ena_5hz = 1'b1; cyc();
    ena_5hz = 1'b0; cyc(); cyc();
  endtask

  initial begin
    // reset state
    #2;
    chk_hms("reset", 0, 0, 0);
    chk("reset.day_tick", int'(day_tick), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // preload 12:34:56 through the set modes
    select_mode = 2'b01; press_up(12);
    select_mode = 2'b10; press_up(34);
    select_mode = 2'b11; press_up(56);
    chk_hms("preload", 12, 34, 56);
    select_mode = 2'b00; cyc(); cyc(); cyc();
    chk_hms("run_idle", 12, 34, 56);
    strobe_1hz();
    chk_hms("run_step", 12, 34, 57);
    press_up(2);
    chk_hms("run_ignores_up", 12, 34, 57);

    // asynchronous reset mid-count
    ena = 1'b1; cyc();
    rst_n = 1'b0; #2;
    chk_hms("async_reset", 0, 0, 0);
    chk("async_reset.day_tick", int'(day_tick), 0);
    ena = 1'b0; cyc();
    rst_n = 1'b1; cyc();

    // sec carry into min
    select_mode = 2'b11; press_dw(1);
    chk_hms("sec_dec_wrap", 0, 0, 59);
    select_mode = 2'b00; strobe_1hz();
    chk_hms("carry_min", 0, 1, 0);

    // min carry into hour
    select_mode = 2'b10; press_up(58);
    select_mode = 2'b11; press_dw(1);
    chk_hms("pre_carry_hour", 0, 59, 59);
    select_mode = 2'b00; strobe_1hz();
    chk_hms("carry_hour", 1, 0, 0);

    // day rollover from 23:59:59
    select_mode = 2'b01; press_dw(2);
    select_mode = 2'b10; press_dw(1);
    select_mode = 2'b11; press_dw(1);
    chk_hms("pre_rollover", 23, 59, 59);
    chk("pre_rollover.day_tick", int'(day_tick), 0);
    select_mode = 2'b00; strobe_1hz();
    chk_hms("rollover", 0, 0, 0);
    chk("rollover.day_tick", int'(day_tick), 1);
    cyc();
    chk("rollover.tick_width", int'(day_tick), 0);

    // a full day of strobes brings no further tick
    ticks = 0;
    ena = 1'b1;
    for (int i = 0; i < 86399; i++) begin
      cyc();
      if (day_tick) ticks++;
    end
    ena = 1'b0;
    chk("day_no_extra_tick", ticks, 0);
    chk_hms("full_day", 23, 59, 59);

    // set-mode wrap without carry
    select_mode = 2'b01; press_up(1);
    chk_hms("hour_inc_wrap", 0, 59, 59);
    select_mode = 2'b10; press_up(1);
    chk_hms("min_inc_wrap", 0, 0, 59);
    press_dw(1);
    chk_hms("min_dec_wrap", 0, 59, 59);
    ena = 1'b1; cyc(); cyc(); cyc();
    ena = 1'b0; cyc();
    chk_hms("set_freezes_run", 0, 59, 59);
    chk("set_no_tick", int'(day_tick), 0);

    // auto-repeat: one edge step plus five 5 Hz steps
    select_mode = 2'b11; press_up(1);
    chk_hms("sec_inc_wrap", 0, 59, 0);
    ena_up = 1'b1; cyc(); cyc();
    for (int i = 0; i < 5; i++) strobe_5hz();
    ena_up = 1'b0; cyc();
    chk("autorepeat", int'(sec), 6);

    // edge coinciding with a 5 Hz strobe is a single step
    ena_up = 1'b1; ena_5hz = 1'b1; cyc();
    ena_5hz = 1'b0; cyc(); cyc();
    ena_up = 1'b0; cyc();
    chk("edge_plus_5hz", int'(sec), 7);

    // conflicting requests do nothing
    ena_up = 1'b1; ena_dw = 1'b1; cyc();
    strobe_5hz(); strobe_5hz();
    ena_up = 1'b0; ena_dw = 1'b0; cyc();
    chk("up_and_dw", int'(sec), 7);

    // held request across a mode change: only 5 Hz repeats act in the new field
    ena_up = 1'b1; cyc();
    chk("held_edge", int'(sec), 8);
    select_mode = 2'b10; cyc(); cyc();
    chk("mode_change_no_edge", int'(min), 59);
    strobe_5hz();
    chk("mode_change_repeat", int'(min), 0);
    ena_up = 1'b0; cyc();
    chk_hms("after_mode_change", 0, 0, 8);

    // resume run from adjusted values
    select_mode = 2'b00; strobe_1hz();
    chk_hms("resume_run", 0, 0, 9);

`ifdef TIME_12H_EN
    chk("h12_midnight.hour12", int'(hour12), 12);
    chk("h12_midnight.pm", int'(pm), 0);
    select_mode = 2'b01; press_up(13);
    chk("h12_13.hour12", int'(hour12), 1);
    chk("h12_13.pm", int'(pm), 1);
    press_dw(1);
    chk("h12_noon.hour12", int'(hour12), 12);
    chk("h12_noon.pm", int'(pm), 1);
    select_mode = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
